// File: rtl/io_port_bank.sv
// Addressed CPU I/O bank: per-channel input holding register and output FIFO.
// Optional registered interrupt output enabled by defining IO_IRQ_EN.
module io_port_bank #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int OUT_DEPTH = 4,
  localparam int AW       = $clog2(NUM_PORTS) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AW-1:0]               io_addr,
  input  logic                        io_wr,
  input  logic                        io_rd,
  input  logic [DATA_W-1:0]           io_wdata,
  output logic [DATA_W-1:0]           io_rdata,
  output logic                        io_rvalid,
  input  logic [NUM_PORTS*DATA_W-1:0] in_port,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_strobe,
  output logic [NUM_PORTS*DATA_W-1:0] out_port,
  output logic [NUM_PORTS-1:0]        out_strobe,
  input  logic [NUM_PORTS-1:0]        out_ack,
  output logic                        irq
);

  localparam int PW = $clog2(OUT_DEPTH);

  logic [NUM_PORTS-1:0][DATA_W-1:0] hold_q, hold_d;
  logic [NUM_PORTS-1:0] in_full_q, in_full_d;
  logic [NUM_PORTS-1:0] in_ovf_q, in_ovf_d;
  logic [NUM_PORTS-1:0] out_ovf_q, out_ovf_d;
  logic [NUM_PORTS-1:0] in_strobe_q, in_strobe_d;
  logic [NUM_PORTS-1:0][PW:0] wp_q, wp_d;
  logic [NUM_PORTS-1:0][PW:0] rp_q, rp_d;
  logic [NUM_PORTS-1:0][OUT_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic rvalid_q, rvalid_d;

  logic [31:0] addr;
  logic [NUM_PORTS-1:0] rd_dat, rd_sts, wr_dat;
  logic [NUM_PORTS-1:0] empty, full, pop;

  assign addr = 32'(io_addr);

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    rd_dat = '0;
    rd_sts = '0;
    wr_dat = '0;
    empty  = '0;
    full   = '0;
    pop    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      rd_dat[k] = io_rd && (addr == 32'(k));
      rd_sts[k] = io_rd && (addr == 32'(NUM_PORTS + k));
      wr_dat[k] = io_wr && (addr == 32'(k));
      empty[k]  = (wp_q[k] == rp_q[k]);
      full[k]   = (wp_q[k][PW] != rp_q[k][PW]) &&
                  (wp_q[k][PW-1:0] == rp_q[k][PW-1:0]);
      pop[k]    = !empty[k] && out_ack[k];
    end
  end

  always_comb begin
    hold_d      = hold_q;
    in_full_d   = in_full_q;
    in_ovf_d    = in_ovf_q;
    out_ovf_d   = out_ovf_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    mem_d       = mem_q;
    in_strobe_d = '0;
    rdata_d     = rdata_q;
    rvalid_d    = io_rd;
    if (io_rd) begin
      rdata_d = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (rd_dat[k]) begin
          rdata_d = hold_q[k];
        end else if (rd_sts[k]) begin
          rdata_d[3:0] = {out_ovf_q[k], in_ovf_q[k],
                          full[k], in_full_q[k]};
        end
      end
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (rd_sts[k]) begin
        in_ovf_d[k]  = 1'b0;
        out_ovf_d[k] = 1'b0;
      end
      if (rd_dat[k] && in_full_q[k]) begin
        in_full_d[k]   = 1'b0;
        in_strobe_d[k] = 1'b1;
      end
      // A same-cycle read frees the slot for the arriving word.
      if (in_valid[k]) begin
        if (!in_full_q[k] || rd_dat[k]) begin
          hold_d[k]    = in_port[k*DATA_W +: DATA_W];
          in_full_d[k] = 1'b1;
        end else begin
          in_ovf_d[k] = 1'b1;
        end
      end
      if (wr_dat[k]) begin
        if (full[k]) begin
          out_ovf_d[k] = 1'b1;
        end else begin
          mem_d[k][wp_q[k][PW-1:0]] = io_wdata;
          wp_d[k] = wp_q[k] + (PW+1)'(1);
        end
      end
      if (pop[k]) begin
        rp_d[k] = rp_q[k] + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      in_full_q   <= '0;
      in_ovf_q    <= '0;
      out_ovf_q   <= '0;
      in_strobe_q <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      mem_q       <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      in_full_q   <= in_full_d;
      in_ovf_q    <= in_ovf_d;
      out_ovf_q   <= out_ovf_d;
      in_strobe_q <= in_strobe_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      mem_q       <= mem_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  always_comb begin
    out_port = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!empty[k]) begin
        out_port[k*DATA_W +: DATA_W] = mem_q[k][rp_q[k][PW-1:0]];
      end
    end
  end

  assign out_strobe = ~empty;
  assign in_strobe  = in_strobe_q;
  assign io_rdata   = rdata_q;
  assign io_rvalid  = rvalid_q;

`ifdef IO_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (|in_full_q) | (|in_ovf_q) | (|out_ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_bank.sv
// Directed vector bench for io_port_bank (default parameters).
// Irq expectations follow IO_IRQ_EN when the bench is built with it.
module tb_io_port_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  io_addr;
  logic        io_wr, io_rd;
  logic [7:0]  io_wdata, io_rdata;
  logic        io_rvalid;
  logic [31:0] in_port, out_port;
  logic [3:0]  in_valid, in_strobe, out_strobe, out_ack;
  logic        irq;

`ifdef IO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  io_port_bank dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_wr(io_wr),
    .io_rd(io_rd), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .io_rvalid(io_rvalid), .in_port(in_port), .in_valid(in_valid),
    .in_strobe(in_strobe), .out_port(out_port),
    .out_strobe(out_strobe), .out_ack(out_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  addr;
    logic [7:0]  wd;
    logic [3:0]  iv;
    logic [31:0] ip;
    logic [3:0]  ack;
    logic        rv;
    logic [7:0]  rdat;
    logic [3:0]  istb, ostb;
    logic [31:0] oport;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] addr,
      logic [7:0] wd, logic [3:0] iv, logic [31:0] ip, logic [3:0] ack,
      logic rv, logic [7:0] rdat, logic [3:0] istb, logic [3:0] ostb,
      logic [31:0] oport);
    vec_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wd = wd; r.iv = iv;
    r.ip = ip; r.ack = ack; r.rv = rv; r.rdat = rdat;
    r.istb = istb; r.ostb = ostb; r.oport = oport;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rd, logic wr, logic [2:0] addr,
      logic [7:0] wd, logic [3:0] iv, logic [31:0] ip, logic [3:0] ack);
    io_rd = rd; io_wr = wr; io_addr = addr; io_wdata = wd;
    in_valid = iv; in_port = ip; out_ack = ack;
  endtask

  task automatic step(logic rd, logic wr, logic [2:0] addr,
      logic [7:0] wd, logic [3:0] iv, logic [31:0] ip, logic [3:0] ack);
    drive(rd, wr, addr, wd, iv, ip, ack);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rd wr addr wd iv ip ack | rv rdat istb ostb oport
    v.push_back(mk(0,0,0,8'h00,4'b0100,32'h00A5_0000,4'b0000, 0,8'h00,4'b0000,4'b0000,32'h0));
    v.push_back(mk(1,0,2,8'h00,4'b0000,32'h0,4'b0000, 1,8'hA5,4'b0100,4'b0000,32'h0));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0000, 0,8'h00,4'b0000,4'b0000,32'h0));
    v.push_back(mk(1,0,2,8'h00,4'b0000,32'h0,4'b0000, 1,8'hA5,4'b0000,4'b0000,32'h0));
    v.push_back(mk(0,0,0,8'h00,4'b0001,32'h11,4'b0000, 0,8'h00,4'b0000,4'b0000,32'h0));
    v.push_back(mk(0,0,0,8'h00,4'b0001,32'h22,4'b0000, 0,8'h00,4'b0000,4'b0000,32'h0));
    v.push_back(mk(1,0,4,8'h00,4'b0000,32'h0,4'b0000, 1,8'h05,4'b0000,4'b0000,32'h0));
    v.push_back(mk(1,0,0,8'h00,4'b0000,32'h0,4'b0000, 1,8'h11,4'b0001,4'b0000,32'h0));
    v.push_back(mk(1,0,4,8'h00,4'b0000,32'h0,4'b0000, 1,8'h00,4'b0000,4'b0000,32'h0));
    for (int i = 1; i <= 5; i++)
      v.push_back(mk(0,1,1,8'(i),4'b0000,32'h0,4'b0000, 0,8'h00,4'b0000,4'b0010,32'h0000_0100));
    v.push_back(mk(1,0,5,8'h00,4'b0000,32'h0,4'b0000, 1,8'h0A,4'b0000,4'b0010,32'h0000_0100));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0010,32'h0000_0200));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0010,32'h0000_0300));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0010,32'h0000_0400));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0000,32'h0));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0000,32'h0));
    v.push_back(mk(0,1,1,8'h66,4'b0000,32'h0,4'b0000, 0,8'h00,4'b0000,4'b0010,32'h0000_6600));
    v.push_back(mk(0,1,1,8'h77,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0010,32'h0000_7700));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0000,32'h0));
    for (int i = 1; i <= 4; i++)
      v.push_back(mk(0,1,1,8'hA0 + 8'(i),4'b0000,32'h0,4'b0000, 0,8'h00,4'b0000,4'b0010,32'h0000_A100));
    v.push_back(mk(0,1,1,8'hA5,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0010,32'h0000_A200));
    v.push_back(mk(1,0,5,8'h00,4'b0000,32'h0,4'b0000, 1,8'h08,4'b0000,4'b0010,32'h0000_A200));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0010,32'h0000_A300));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0010,32'h0000_A400));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0000,32'h0));
    v.push_back(mk(0,0,0,8'h00,4'b0001,32'h33,4'b0000, 0,8'h00,4'b0000,4'b0000,32'h0));
    v.push_back(mk(1,0,0,8'h00,4'b0001,32'h44,4'b0000, 1,8'h33,4'b0001,4'b0000,32'h0));
    v.push_back(mk(1,0,4,8'h00,4'b0000,32'h0,4'b0000, 1,8'h01,4'b0000,4'b0000,32'h0));
    v.push_back(mk(1,0,0,8'h00,4'b0000,32'h0,4'b0000, 1,8'h44,4'b0001,4'b0000,32'h0));
    v.push_back(mk(0,1,6,8'hFF,4'b0000,32'h0,4'b0000, 0,8'h00,4'b0000,4'b0000,32'h0));
    v.push_back(mk(1,0,6,8'h00,4'b0000,32'h0,4'b0000, 1,8'h00,4'b0000,4'b0000,32'h0));
    v.push_back(mk(1,1,1,8'h5A,4'b0000,32'h0,4'b0000, 1,8'h00,4'b0000,4'b0010,32'h0000_5A00));
    v.push_back(mk(0,0,0,8'h00,4'b0000,32'h0,4'b0010, 0,8'h00,4'b0000,4'b0000,32'h0));

    rst = 1'b1;
    drive(0,0,0,8'h00,4'b0000,32'h0,4'b0000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset rdata", 32'(io_rdata), 32'h0);
    chk("reset rvalid", 32'(io_rvalid), 32'h0);
    chk("reset in_strobe", 32'(in_strobe), 32'h0);
    chk("reset out_strobe", 32'(out_strobe), 32'h0);
    chk("reset out_port", out_port, 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rd, v[i].wr, v[i].addr, v[i].wd, v[i].iv, v[i].ip, v[i].ack);
      chk($sformatf("v%0d rvalid", i), 32'(io_rvalid), 32'(v[i].rv));
      if (v[i].rv)
        chk($sformatf("v%0d rdata", i), 32'(io_rdata), 32'(v[i].rdat));
      chk($sformatf("v%0d in_strobe", i), 32'(in_strobe), 32'(v[i].istb));
      chk($sformatf("v%0d out_strobe", i), 32'(out_strobe), 32'(v[i].ostb));
      chk($sformatf("v%0d out_port", i), out_port, v[i].oport);
    end

    // Reset in the middle of a drain with two words queued on ch2.
    step(0,1,2,8'hC1,4'b1000,32'h1100_0000,4'b0000);
    step(0,1,2,8'hC2,4'b1000,32'h2200_0000,4'b0000);
    step(0,1,2,8'hC3,4'b0000,32'h0,4'b0100);
    drive(0,0,0,8'h00,4'b0000,32'h0,4'b0100);
    chk("pre-rst out_strobe", 32'(out_strobe), 32'h4);
    chk("pre-rst out_port", out_port, 32'h00C2_0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async rst out_strobe", 32'(out_strobe), 32'h0);
    chk("async rst out_port", out_port, 32'h0);
    drive(0,0,0,8'h00,4'b0000,32'h0,4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1,0,3'(4 + k),8'h00,4'b0000,32'h0,4'b0000);
      chk($sformatf("post-rst status%0d", k), 32'(io_rdata), 32'h0);
      chk($sformatf("post-rst rvalid%0d", k), 32'(io_rvalid), 32'h1);
    end
    chk("post-rst out_strobe", 32'(out_strobe), 32'h0);
    step(1,0,3,8'h00,4'b0000,32'h0,4'b0000);
    chk("post-rst hold3", 32'(io_rdata), 32'h0);

    // Interrupt follows the flags one cycle late.
    step(0,0,0,8'h00,4'b1000,32'h5E00_0000,4'b0000);
    chk("irq flag edge", 32'(irq), 32'h0);
    step(0,0,0,8'h00,4'b0000,32'h0,4'b0000);
    chk("irq raised", 32'(irq), 32'(IRQ_ON));
    step(1,0,3,8'h00,4'b0000,32'h0,4'b0000);
    chk("irq read data", 32'(io_rdata), 32'h5E);
    chk("irq read edge", 32'(irq), 32'(IRQ_ON));
    step(0,0,0,8'h00,4'b0000,32'h0,4'b0000);
    chk("irq cleared", 32'(irq), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
